// File: rtl/pulse_gen_1ms_core_if.sv
// Output bundle of the millisecond strobe generator; pulse_seq exists only with PULSE_GEN_SEQ_EN.
interface pulse_gen_1ms_core_if;
  logic pulse;
`ifdef PULSE_GEN_SEQ_EN
  logic [15:0] pulse_seq;

  modport master (output pulse, output pulse_seq);
  modport slave  (input  pulse, input  pulse_seq);
`else
  modport master (output pulse);
  modport slave  (input  pulse);
`endif
endinterface

// File: rtl/pulse_gen_1ms_core.sv
// Free-running strobe: one-cycle registered pulse every PERIOD_CYCLES clocks, no backpressure.
// Optional 16-bit pulse sequence number when PULSE_GEN_SEQ_EN is defined.
module pulse_gen_1ms_core #(
  parameter int CLK_FREQ_HZ = 1_000_000,
  parameter int PERIOD_US   = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  pulse_gen_1ms_core_if.master  pg
);

  // Elaboration-time derivation; PERIOD_CYCLES must be >= 2.
  localparam int PERIOD_CYCLES = CLK_FREQ_HZ / 1_000_000 * PERIOD_US;
  localparam int CNT_W         = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PERIOD_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pulse_q, pulse_d;
  logic             wrap;

  // Equality compare keeps the counter inside 0..PERIOD_CYCLES-1 for any period.
  always_comb begin
    wrap    = (cnt_q == CNT_LAST);
    cnt_d   = wrap ? '0 : cnt_q + CNT_W'(1);
    pulse_d = wrap;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      pulse_q <= 1'b0;
    end else begin
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
    end
  end

  assign pg.pulse = pulse_q;

`ifdef PULSE_GEN_SEQ_EN
  logic [15:0] seq_q, seq_d;

  // Advances on the same edge that raises pulse, so the first pulse carries 1.
  always_comb begin
    seq_d = pulse_d ? seq_q + 16'd1 : seq_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign pg.pulse_seq = seq_q;
`endif

endmodule

// File: tb/tb_pulse_gen_1ms_core.sv
// Directed self-checking bench for pulse_gen_1ms_core (default 1000-cycle period).
// Sequence-number checks are compiled in when PULSE_GEN_SEQ_EN is defined.
module tb_pulse_gen_1ms_core;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  pulse_gen_1ms_core_if ifc ();

  pulse_gen_1ms_core dut (
    .clk (clk),
    .rst (rst),
    .pg  (ifc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Counts rising edges until pulse is seen (sampled 1 time unit after the edge).
  // Returns -1 if the budget expires.
  task automatic run_to_pulse(input int budget, output int edges);
    edges = -1;
    for (int i = 1; i <= budget; i++) begin
      @(posedge clk);
      #1;
      if (ifc.pulse === 1'b1) begin
        edges = i;
        break;
      end
    end
  endtask

  task automatic step_chk_low(input string tag);
    @(posedge clk);
    #1;
    chk(tag, 32'(ifc.pulse), 32'd0);
  endtask

  int e1, e2, e3, e4, e5;
  int total;

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;

    // Reset held for 5 clocks: pulse stays low.
    for (int i = 0; i < 5; i++) step_chk_low("reset_hold_pulse");
`ifdef PULSE_GEN_SEQ_EN
    chk("reset_seq", 32'(ifc.pulse_seq), 32'd0);
`endif

    @(negedge clk);
    rst = 1'b0;

    // First pulse exactly at the 1000th edge after release.
    run_to_pulse(5000, e1);
    chk("first_pulse_edge", 32'(e1), 32'd1000);
    step_chk_low("pulse_width_1");

    run_to_pulse(5000, e2);
    chk("interval_1_2", 32'(e2 + 1), 32'd1000);
    step_chk_low("pulse_width_2");

    run_to_pulse(5000, e3);
    chk("interval_2_3", 32'(e3 + 1), 32'd1000);
    total = e1 + (e2 + 1) + (e3 + 1);
    chk("watchdog_3_pulses", 32'((e1 > 0) && (e2 > 0) && (e3 > 0) && (total <= 5000)), 32'd1);
`ifdef PULSE_GEN_SEQ_EN
    chk("seq_after_3", 32'(ifc.pulse_seq), 32'd3);
`endif
    step_chk_low("pulse_width_3");

    // Mid-period reset around cycle 500 of the period, held for 3 clocks.
    repeat (498) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_pulse_async", 32'(ifc.pulse), 32'd0);
    for (int i = 0; i < 3; i++) step_chk_low("midreset_hold_pulse");
    @(negedge clk);
    rst = 1'b0;
    run_to_pulse(5000, e4);
    chk("after_midreset_edge", 32'(e4), 32'd1000);
`ifdef PULSE_GEN_SEQ_EN
    chk("seq_after_midreset", 32'(ifc.pulse_seq), 32'd1);
`endif

    // Reset while pulse is high: pulse must drop without waiting for a clock.
    #2;
    rst = 1'b1;
    #1;
    chk("reset_while_high", 32'(ifc.pulse), 32'd0);
`ifdef PULSE_GEN_SEQ_EN
    chk("seq_async_clear", 32'(ifc.pulse_seq), 32'd0);
`endif
    @(negedge clk);
    rst = 1'b0;
    run_to_pulse(5000, e5);
    chk("after_high_reset_edge", 32'(e5), 32'd1000);

`ifdef PULSE_GEN_SEQ_EN
    // Preload the sequence to 16'hFFFF; the next pulse must wrap it to 0.
    #1;
    force dut.seq_q = 16'hFFFF;
    #1;
    release dut.seq_q;
    chk("seq_preload", 32'(ifc.pulse_seq), 32'hFFFF);
    run_to_pulse(5000, e5);
    chk("wrap_interval", 32'(e5), 32'd1000);
    chk("seq_wrap", 32'(ifc.pulse_seq), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
